// File: rtl/branch_fwd_ctrl.sv
// ID-stage branch comparator control: shadow EX/MEM/WB producer slots, operand forward selects and stall.
// Optional BRANCH_STALL_CNT_EN adds a saturating stall-cycle counter on stall_cnt_o.

module branch_fwd_lane #(
  parameter int          REG_AW    = 5,
  parameter logic [1:0]  WBSEL_ALU = 2'b01
) (
  input  logic                   chk,
  input  logic [REG_AW-1:0]      rs,
  input  logic [2:0][REG_AW-1:0] slot_rd,
  input  logic [2:0]             slot_rw,
  input  logic [1:0]             mem_wbsel,
  output logic [1:0]             sel,
  output logic                   hazard
);
  logic [2:0] hit;

  always_comb begin
    for (int i = 0; i < 3; i++)
      hit[i] = slot_rw[i] && (slot_rd[i] != '0) && (slot_rd[i] == rs);
  end

  // Youngest producer wins: EX, then MEM, then WB.
  always_comb begin
    sel    = 2'b00;
    hazard = 1'b0;
    if (chk) begin
      if (hit[0])
        hazard = 1'b1;
      else if (hit[1]) begin
        if (mem_wbsel == WBSEL_ALU) sel = 2'b10;
        else                        hazard = 1'b1;
      end
      else if (hit[2])
        sel = 2'b01;
    end
  end
endmodule

module branch_fwd_ctrl #(
  parameter int          REG_AW    = 5,
  parameter logic [1:0]  WBSEL_ALU = 2'b01,
  parameter int          STALL_CW  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid_i,
  input  logic              id_is_branch_i,
  input  logic              id_uses_rs2_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic [1:0]        id_wbsel_i,
  input  logic              flush_i,
  output logic [1:0]        forwardBranchA,
  output logic [1:0]        forwardBranchB,
  output logic              stall_o
`ifdef BRANCH_STALL_CNT_EN
  ,
  output logic [STALL_CW-1:0] stall_cnt_o
`endif
);
  localparam int EX = 0, MEM = 1, WB = 2, NUM_OPS = 2;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic [1:0]        wbsel;
  } slot_t;

  slot_t [2:0] slot_q;
  logic        issue;

  logic [2:0][REG_AW-1:0]         slot_rd;
  logic [2:0]                     slot_rw;
  logic [NUM_OPS-1:0][REG_AW-1:0] lane_rs;
  logic [NUM_OPS-1:0]             lane_chk;
  logic [NUM_OPS-1:0][1:0]        lane_sel;
  logic [NUM_OPS-1:0]             lane_haz;

  // Only MEM needs wbsel; EX/WB copies ride along for the shadow pipeline.
  logic unused_wbsel;
  assign unused_wbsel = ^{slot_q[EX].wbsel, slot_q[WB].wbsel};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      slot_rd[i] = slot_q[i].rd;
      slot_rw[i] = slot_q[i].regwrite;
    end
  end

  assign lane_rs  = {id_rs2_i, id_rs1_i};
  assign lane_chk = {id_is_branch_i & id_uses_rs2_i, id_is_branch_i};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_lane
    branch_fwd_lane #(.REG_AW(REG_AW), .WBSEL_ALU(WBSEL_ALU)) u_lane (
      .chk       (lane_chk[g]),
      .rs        (lane_rs[g]),
      .slot_rd   (slot_rd),
      .slot_rw   (slot_rw),
      .mem_wbsel (slot_q[MEM].wbsel),
      .sel       (lane_sel[g]),
      .hazard    (lane_haz[g])
    );
  end

  assign forwardBranchA = lane_sel[0];
  assign forwardBranchB = lane_sel[1];
  assign stall_o        = id_valid_i & id_is_branch_i & (|lane_haz);
  assign issue          = id_valid_i & ~stall_o & ~flush_i;

  // Stalled or flushed cycles inject a bubble so the producer keeps draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q[WB]  <= slot_q[MEM];
      slot_q[MEM] <= slot_q[EX];
      slot_q[EX]  <= issue ? slot_t'{rd: id_rd_i, regwrite: id_regwrite_i, wbsel: id_wbsel_i}
                           : slot_t'('0);
    end
  end

`ifdef BRANCH_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt_o <= '0;
    else if (stall_o && (stall_cnt_o != '1))
      stall_cnt_o <= stall_cnt_o + 1'b1;
  end
`endif
endmodule
